lc3_mem_ctrl: RTL and testbench

- CPU-side initiator for the LC-3 main memory: the MAR/MDR access controller.
- Accepts one read or write request at a time from the datapath/control FSM.
- Drives the memory's we/re/raddr/waddr/d strobes and waits for the memory ready bit.
- Returns read data through an MDR register, with a one-cycle done pulse per access.

---
 rtl/lc3_mem_pkg.sv | 21 ++
 rtl/lc3_mem_watchdog.sv | 28 ++
 rtl/lc3_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 MAR/MDR memory access controller.
package lc3_mem_pkg;

  localparam int unsigned LC3_MEM_ADDR_W = 7;
  localparam int unsigned LC3_DATA_W     = 16;
  localparam int unsigned LC3_CPU_ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CAPT,
    DONE
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage : lc3_mem_pkg

// File: rtl/lc3_mem_watchdog.sv
// Ready-wait counter for lc3_mem_ctrl; only instantiated when MEM_TIMEOUT_EN is defined.
// expire is asserted in the wait cycle whose edge would complete TIMEOUT not-ready cycles.
module lc3_mem_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt;

  assign expire = tick && (cnt == CNT_W'(TIMEOUT - 1));

  // Count not-ready cycles while a strobe is outstanding; held clear otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule : lc3_mem_watchdog

// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR memory access controller: one read or write at a time,
// strobes driven from registered state, one-cycle done pulse per access.
// Optional feature macro: MEM_TIMEOUT_EN (abort a ready-wait after TIMEOUT cycles).
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = LC3_MEM_ADDR_W,
  parameter int unsigned DATA_W     = LC3_DATA_W,
  parameter int unsigned CPU_ADDR_W = LC3_CPU_ADDR_W,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  req_we,
  input  logic [CPU_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [ADDR_W-1:0]     mem_raddr,
  output logic [DATA_W-1:0]     mem_d,
  input  logic [DATA_W-1:0]     mem_dout,
  input  logic                  mem_ready
);

  // A zero TIMEOUT would abort before the memory could ever answer.
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("lc3_mem_ctrl: TIMEOUT must be at least 1");
  end

  state_t            state;
  op_t               op_q;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              out_of_range;
  logic              expire;

  assign out_of_range = |addr[CPU_ADDR_W-1:ADDR_W];

  // MAR/MDR are registers, so the memory bus is glitch-free and stable while strobed.
  assign mem_waddr = mar;
  assign mem_raddr = mar;
  assign mem_d     = mdr;

`ifdef MEM_TIMEOUT_EN
  logic wd_clr;
  logic wd_tick;

  assign wd_clr  = !((state == WRITE) || (state == READ));
  assign wd_tick = ((state == WRITE) || (state == READ)) && !mem_ready;

  lc3_mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .tick   (wd_tick),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  // Access FSM; every output is loaded on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= OP_RD;
      mar    <= '0;
      mdr    <= '0;
      rdata  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            mar  <= addr[ADDR_W-1:0];
            mdr  <= wdata;
            op_q <= req_we ? OP_WR : OP_RD;
            busy <= 1'b1;
            if (out_of_range) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (req_we) begin
              state  <= WRITE;
              mem_we <= 1'b1;
            end else begin
              state  <= READ;
              mem_re <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_we <= 1'b0;
            state  <= DONE;
            done   <= 1'b1;
          end else if (expire) begin
            mem_we <= 1'b0;
            state  <= DONE;
            done   <= 1'b1;
            err    <= 1'b1;
          end
        end
        READ: begin
          if (mem_ready) begin
            mem_re <= 1'b0;
            state  <= CAPT;
          end else if (expire) begin
            mem_re <= 1'b0;
            state  <= DONE;
            done   <= 1'b1;
            err    <= 1'b1;
          end
        end
        CAPT: begin
          mdr <= mem_dout;
          if (op_q == OP_RD) begin
            rdata <= mem_dout;
          end
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          err    <= 1'b0;
          mem_we <= 1'b0;
          mem_re <= 1'b0;
        end
      endcase
    end
  end

endmodule : lc3_mem_ctrl

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: directed accesses from the test plan plus
// randomized traffic, scored against a transaction-level memory model.
module tb_lc3_mem_ctrl;

  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned CPU_ADDR_W = 16;
  localparam int unsigned TIMEOUT    = 15;
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO_LIMIT   = TIMEOUT;
`else
  localparam int unsigned TO_LIMIT   = 1000;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  req;
  logic                  req_we;
  logic [CPU_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]     wdata;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [DATA_W-1:0]     rdata;
  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [ADDR_W-1:0]     mem_raddr;
  logic [DATA_W-1:0]     mem_d;
  logic [DATA_W-1:0]     mem_dout;
  logic                  mem_ready;

  always #5 clk = ~clk;

  lc3_mem_ctrl #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .CPU_ADDR_W (CPU_ADDR_W),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_waddr (mem_waddr),
    .mem_raddr (mem_raddr),
    .mem_d     (mem_d),
    .mem_dout  (mem_dout),
    .mem_ready (mem_ready)
  );

  logic [DATA_W-1:0] slave_mem [128];
  logic [DATA_W-1:0] ref_mem   [128];
  logic [DATA_W-1:0] exp_rdata;
  int unsigned       n_checks = 0;
  int unsigned       n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock: the bench memory samples the bus as it stands before the edge,
  // then presents registered read data just after it.
  task automatic tick();
    logic              we_s, re_s, rdy_s;
    logic [ADDR_W-1:0] wa_s, ra_s;
    logic [DATA_W-1:0] d_s;
    we_s = mem_we; re_s = mem_re; rdy_s = mem_ready;
    wa_s = mem_waddr; ra_s = mem_raddr; d_s = mem_d;
    @(posedge clk);
    #1;
    if (we_s === 1'b1 && rdy_s === 1'b1) slave_mem[wa_s] = d_s;
    if (re_s === 1'b1 && rdy_s === 1'b1) mem_dout = slave_mem[ra_s];
  endtask

  // Issue one access from IDLE. stall = strobe cycles with ready low before it rises.
  // poke = pulse a second, random req while the first access is in flight.
  task automatic do_access(input logic we, input logic [15:0] a, input logic [15:0] wd,
                           input int unsigned stall, input logic poke, input string name);
    bit          oor, tmo;
    int unsigned exp_strobes, exp_done;
    int unsigned we_cyc = 0, re_cyc = 0, overlap = 0, bad_bus = 0;
    int unsigned dones = 0, done_at = 0;
    logic        err_at_done = 1'b0, busy_at_done = 1'b0;
    logic [15:0] rdata_at_done = '0;
    oor = (a >= 16'd128);
    tmo = !oor && (stall >= TO_LIMIT);
    if (oor) begin
      exp_strobes = 0; exp_done = 1;
    end else if (tmo) begin
      exp_strobes = TIMEOUT; exp_done = TIMEOUT + 1;
    end else begin
      exp_strobes = stall + 1; exp_done = we ? stall + 2 : stall + 3;
    end
    if (!oor && !tmo) begin
      if (we) ref_mem[a[6:0]] = wd;
      else    exp_rdata = ref_mem[a[6:0]];
    end

    req = 1'b1; req_we = we; addr = a; wdata = wd;
    mem_ready = 1'($urandom_range(0, 1));
    for (int unsigned c = 1; c <= 80; c++) begin
      tick();
      if (c == 1 && poke && !oor) begin
        req = 1'b1; req_we = 1'($urandom_range(0, 1));
        addr = 16'($urandom_range(0, 127)); wdata = 16'($urandom);
      end else begin
        req = 1'b0;
      end
      if (mem_we && mem_re) overlap++;
      if (mem_we) begin
        we_cyc++;
        if (mem_waddr !== a[6:0] || mem_d !== wd) bad_bus++;
      end
      if (mem_re) begin
        re_cyc++;
        if (mem_raddr !== a[6:0]) bad_bus++;
      end
      if (done === 1'b1) begin
        dones++;
        if (done_at == 0) begin
          done_at = c; err_at_done = err; busy_at_done = busy; rdata_at_done = rdata;
        end
      end
      if (mem_we || mem_re) mem_ready = ((we_cyc + re_cyc) > stall);
      else                  mem_ready = 1'($urandom_range(0, 1));
      if (done_at != 0 && c == done_at + 1) break;
    end

    check({name, ".done_at"}, 64'(done_at), 64'(exp_done));
    check({name, ".done_cnt"}, 64'(dones), 64'd1);
    check({name, ".err"}, 64'(err_at_done), 64'(oor || tmo));
    check({name, ".busy"}, 64'(busy_at_done), 64'd1);
    check({name, ".we_cyc"}, 64'(we_cyc), (we && !oor) ? 64'(exp_strobes) : 64'd0);
    check({name, ".re_cyc"}, 64'(re_cyc), (!we && !oor) ? 64'(exp_strobes) : 64'd0);
    check({name, ".overlap"}, 64'(overlap), 64'd0);
    check({name, ".bus"}, 64'(bad_bus), 64'd0);
    check({name, ".rdata_done"}, 64'(rdata_at_done), 64'(exp_rdata));
    check({name, ".idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    logic [15:0] ra;
    for (int i = 0; i < 128; i++) begin
      slave_mem[i] = 16'($urandom);
      ref_mem[i]   = slave_mem[i];
    end
    exp_rdata = '0;
    rst_n = 1'b0; req = 1'b0; req_we = 1'b0; addr = '0; wdata = '0;
    mem_dout = '0; mem_ready = 1'b1;
    tick(); tick();
    check("reset_outs", {13'd0, busy, done, err, mem_we, mem_re, rdata, mem_waddr, mem_raddr, mem_d}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed accesses from the test plan
    do_access(1'b1, 16'h0005, 16'hBEEF, 0, 1'b0, "wr5");
    do_access(1'b0, 16'h0005, 16'h0000, 0, 1'b0, "rd5");
    do_access(1'b0, 16'h3000, 16'h0000, 0, 1'b0, "oor");
    check("oor_rdata", 64'(rdata), 64'h0000_0000_0000_BEEF);
    do_access(1'b0, 16'h007F, 16'h0000, 4, 1'b0, "stall7f");
    do_access(1'b1, 16'h0020, 16'h5A5A, 1, 1'b1, "poke_wr");
    do_access(1'b0, 16'h0020, 16'h0000, 0, 1'b0, "poke_rd");

    // Reset in the middle of a stalled read
    req = 1'b1; req_we = 1'b0; addr = 16'h0010; mem_ready = 1'b0;
    tick();
    req = 1'b0;
    check("mid_re", 64'(mem_re), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_rdata = '0;
    check("mid_rst_outs", {13'd0, busy, done, err, mem_we, mem_re, rdata, mem_waddr, mem_raddr, mem_d}, 64'd0);
    mem_ready = 1'b1;
    tick();
    check("post_rst", {61'd0, busy, done, mem_re}, 64'd0);
    do_access(1'b1, 16'h0001, 16'h1234, 0, 1'b0, "wr1");
    do_access(1'b0, 16'h0001, 16'h0000, 0, 1'b0, "rd1");

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) ra = 16'($urandom_range(128, 65535));
      else                           ra = 16'($urandom_range(0, 127));
      do_access(1'($urandom_range(0, 1)), ra, 16'($urandom),
                $urandom_range(0, 5), 1'($urandom_range(0, 1)), "rnd");
    end

`ifdef MEM_TIMEOUT_EN
    do_access(1'b1, 16'h0033, 16'hDEAD, 200, 1'b0, "tmo_wr");
    do_access(1'b0, 16'h0033, 16'h0000, 0, 1'b0, "tmo_rdback");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_lc3_mem_ctrl
